// File: rtl/redmule_pkg.sv
// Shared types and constants for the RedMulE Z-buffer writeback path.
package redmule_pkg;

  localparam int unsigned ZBUF_DRAIN_DEPTH     = 3;
  localparam int unsigned ZBUF_DRAIN_WORD_SIZE = 32;
  localparam int unsigned ZBUF_DRAIN_COLS      = 4;

  typedef enum logic [1:0] {
    StIdle,
    StDrain,
    StFlush
  } z_drain_state_e;

  // Default beat layout; users with other geometries pass their own type to the FIFO.
  typedef struct packed {
    logic [ZBUF_DRAIN_COLS*ZBUF_DRAIN_WORD_SIZE-1:0] data;
    logic                                            last;
  } z_beat_t;

endpackage

// File: rtl/redmule_z_drain_fifo.sv
// Small register FIFO with push/pop/count and synchronous clear.
module redmule_z_drain_fifo
  import redmule_pkg::*;
#(
  parameter int unsigned Depth  = ZBUF_DRAIN_DEPTH,
  parameter type         beat_t = z_beat_t,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = $clog2(Depth)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            push_i,
  input  beat_t           data_i,
  input  logic            pop_i,
  output beat_t           data_o,
  output logic [CntW-1:0] cnt_o,
  output logic            empty_o
);

  beat_t           mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic            full;

  // Pointers wrap explicitly since Depth need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full    = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  overflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    (push_i && full) |-> pop_i);
  underflow_a : assert property (@(posedge clk_i) disable iff (!rst_ni || clear_i)
    pop_i |-> !empty_o);

endmodule

// File: rtl/redmule_z_drain.sv
// Drains a completed Z tile row by row onto a valid/ready stream with column strobes.
module redmule_z_drain
  import redmule_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ROWS      = 4,
  parameter int unsigned COLS      = 4,
  localparam int unsigned RowW     = $clog2(ROWS + 1),
  localparam int unsigned ColW     = $clog2(COLS + 1),
  localparam int unsigned AddrW    = $clog2(ROWS),
  localparam int unsigned BeatW    = COLS * WORD_SIZE,
  localparam int unsigned StrbW    = BeatW / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [RowW-1:0]  rows_i,
  input  logic [ColW-1:0]  cols_i,
  output logic             row_read_en_o,
  output logic [AddrW-1:0] row_read_addr_o,
  input  logic [BeatW-1:0] row_rdata_i,
  output logic [BeatW-1:0] data_o,
  output logic [StrbW-1:0] strb_o,
  output logic             last_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned FifoCntW = $clog2(ZBUF_DRAIN_DEPTH + 1);

  typedef struct packed {
    logic [BeatW-1:0] data;
    logic             last;
  } beat_t;

  z_drain_state_e    state_q, state_d;
  logic [RowW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [RowW-1:0]   rows_q, rows_d;
  logic [ColW-1:0]   cols_q, cols_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  logic              push, pop, fifo_empty;
  beat_t             fifo_in, fifo_out;
  logic [FifoCntW-1:0] fifo_cnt, fifo_cnt_next;
  logic [FifoCntW:0] credit_used;

  // Rows in the FIFO plus the row in flight must never exceed the FIFO depth.
  assign credit_used   = (FifoCntW+1)'(fifo_cnt) + (FifoCntW+1)'(inflight_q);
  assign row_read_en_o = (state_q == StDrain) && (rd_cnt_q < rows_q) &&
                         (credit_used < (FifoCntW+1)'(ZBUF_DRAIN_DEPTH));
  assign row_read_addr_o = rd_cnt_q[AddrW-1:0];

  assign push          = inflight_q && !clear_i;
  assign fifo_in       = '{data: row_rdata_i, last: inflight_last_q};
  assign valid_o       = !fifo_empty;
  assign pop           = valid_o && ready_i;
  assign fifo_cnt_next = fifo_cnt + FifoCntW'(push) - FifoCntW'(pop);

  assign data_o = fifo_out.data;
  assign last_o = fifo_out.last;
  assign busy_o = (state_q != StIdle);
  assign done_o = done_q;

  redmule_z_drain_fifo #(
    .Depth  (ZBUF_DRAIN_DEPTH),
    .beat_t (beat_t)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (fifo_in),
    .pop_i   (pop),
    .data_o  (fifo_out),
    .cnt_o   (fifo_cnt),
    .empty_o (fifo_empty)
  );

  // Byte strobes enable only the valid columns; data is never masked.
  always_comb begin
    strb_o = '0;
    for (int c = 0; c < COLS; c++) begin
      strb_o[c*WORD_SIZE/8 +: WORD_SIZE/8] = (c < int'(cols_q)) ? '1 : '0;
    end
  end

  // Next state, read counter and tile-parameter latching; clear overrides everything.
  always_comb begin
    state_d         = state_q;
    rd_cnt_d        = rd_cnt_q;
    rows_d          = rows_q;
    cols_d          = cols_q;
    done_d          = 1'b0;
    inflight_d      = row_read_en_o;
    inflight_last_d = inflight_last_q;

    if (row_read_en_o) begin
      rd_cnt_d        = rd_cnt_q + RowW'(1);
      inflight_last_d = ((rd_cnt_q + RowW'(1)) == rows_q);
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StDrain;
          rows_d   = rows_i;
          cols_d   = cols_i;
          rd_cnt_d = '0;
        end
      end
      StDrain, StFlush: begin
        // Look one edge ahead so done lands right after the last beat is taken.
        if ((rd_cnt_d == rows_q) && !inflight_d && (fifo_cnt_next == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else if (rd_cnt_d == rows_q) begin
          state_d = StFlush;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear_i) begin
      state_d         = StIdle;
      rd_cnt_d        = '0;
      inflight_d      = 1'b0;
      inflight_last_d = 1'b0;
      done_d          = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      rd_cnt_q        <= '0;
      rows_q          <= '0;
      cols_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rd_cnt_q        <= rd_cnt_d;
      rows_q          <= rows_d;
      cols_q          <= cols_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_redmule_z_drain.sv
// Randomized self-checking bench for redmule_z_drain against a transaction-level model.
module tb_redmule_z_drain;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ROWS      = 4;
  localparam int unsigned COLS      = 4;
  localparam int unsigned BeatW     = COLS * WORD_SIZE;
  localparam int unsigned StrbW     = BeatW / 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             clear_i;
  logic             start_i;
  logic [2:0]       rows_i;
  logic [2:0]       cols_i;
  logic             row_read_en_o;
  logic [1:0]       row_read_addr_o;
  logic [BeatW-1:0] row_rdata_i;
  logic [BeatW-1:0] data_o;
  logic [StrbW-1:0] strb_o;
  logic             last_o;
  logic             valid_o;
  logic             ready_i;
  logic             busy_o;
  logic             done_o;

  logic [BeatW-1:0] zmem [ROWS];
  int               n_total = 0;
  int               n_bad   = 0;

  always #5 clk_i = ~clk_i;

  redmule_z_drain #(
    .WORD_SIZE (WORD_SIZE),
    .ROWS      (ROWS),
    .COLS      (COLS)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .clear_i         (clear_i),
    .start_i         (start_i),
    .rows_i          (rows_i),
    .cols_i          (cols_i),
    .row_read_en_o   (row_read_en_o),
    .row_read_addr_o (row_read_addr_o),
    .row_rdata_i     (row_rdata_i),
    .data_o          (data_o),
    .strb_o          (strb_o),
    .last_o          (last_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  // Z buffer: data one cycle after the request edge, garbage otherwise.
  always @(posedge clk_i) begin
    if (row_read_en_o) row_rdata_i <= zmem[row_read_addr_o];
    else               row_rdata_i <= {$urandom(), $urandom(), $urandom(), $urandom()};
  end

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [StrbW-1:0] strb_model(input int cols);
    logic [StrbW-1:0] s;
    for (int b = 0; b < StrbW; b++) s[b] = ((b / (WORD_SIZE / 8)) < cols);
    return s;
  endfunction

  task automatic fill_zmem(input bit pattern);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        zmem[r][c*WORD_SIZE +: WORD_SIZE] = pattern ? 32'(32'h1000 * r + c) : $urandom();
  endtask

  // One tile: model tracks reads issued and beats taken; optional start poke mid-drain.
  task automatic run_tile(input int rows, input int cols, input bit rnd_ready,
                          input bit timed, input bit poke);
    int cyc = 0, beats = 0, reads = 0, dones = 0;
    int first_rd = -1, first_vld = -1, done_cyc = -1;
    bit seen_done = 0;
    fill_zmem(timed);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    rows_i  = 3'(rows);
    cols_i  = 3'(cols);
    ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    while (cyc < 200 && !(seen_done && cyc > done_cyc + 2)) begin
      @(negedge clk_i);
      if (row_read_en_o) begin
        if (first_rd < 0) first_rd = cyc;
        check_eq("rd_addr", row_read_addr_o, reads);
        check_eq("credit", ((reads - beats) < 3), 1);
        reads++;
      end
      if (valid_o) begin
        if (first_vld < 0) first_vld = cyc;
        if (beats >= rows) check_eq("extra_beat", beats, rows - 1);
        else begin
          check_eq("data", data_o, zmem[beats]);
          check_eq("strb", strb_o, strb_model(cols));
          check_eq("last", last_o, (beats == rows - 1));
        end
        if (ready_i) beats++;
      end
      if (done_o) begin
        dones++;
        if (!seen_done) begin
          seen_done = 1;
          done_cyc  = cyc;
          check_eq("busy_at_done", busy_o, 0);
        end
      end
      if (cyc == 1) check_eq("busy_c1", busy_o, 1);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      if (poke && cyc + 1 == 3) begin
        start_i = 1'b1;
        rows_i  = 3'd1;
      end
      ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    start_i = 1'b0;
    if (!seen_done) check_eq("timeout", 0, 1);
    check_eq("beat_count", beats, rows);
    check_eq("read_count", reads, rows);
    check_eq("done_count", dones, 1);
    if (rows == 0) check_eq("no_valid", first_vld, -1);
    if (timed) begin
      if (rows == 0) check_eq("done_cyc_zero", done_cyc, 2);
      else begin
        check_eq("first_rd", first_rd, 1);
        check_eq("first_vld", first_vld, 3);
        check_eq("done_cyc", done_cyc, 3 + rows);
      end
    end
  endtask

  // Clear after beat 1 is taken, with the consumer stalled.
  task automatic clear_mid_drain();
    fill_zmem(1);
    @(posedge clk_i); #1;
    start_i = 1'b1; rows_i = 3'd4; cols_i = 3'd4; ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      start_i = 1'b0;
    end
    clear_i = 1'b1;
    ready_i = 1'b0;
    @(negedge clk_i);
    check_eq("pre_clear_valid", valid_o, 1);
    check_eq("pre_clear_data", data_o, zmem[2]);
    @(posedge clk_i); #1;
    clear_i = 1'b0;
    @(negedge clk_i);
    check_eq("clr_valid", valid_o, 0);
    check_eq("clr_busy", busy_o, 0);
    check_eq("clr_rd_en", row_read_en_o, 0);
    for (int k = 0; k < 3; k++) begin
      check_eq("clr_no_done", done_o, 0);
      check_eq("clr_no_valid", valid_o, 0);
      @(negedge clk_i);
    end
  endtask

  initial begin
    rst_ni  = 1'b0;
    clear_i = 1'b0;
    start_i = 1'b0;
    ready_i = 1'b0;
    rows_i  = '0;
    cols_i  = '0;
    for (int r = 0; r < ROWS; r++) zmem[r] = '0;
    #12;
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_done", done_o, 0);
    check_eq("rst_rd_en", row_read_en_o, 0);
    check_eq("rst_strb", strb_o, 0);
    check_eq("rst_last", last_o, 0);
    check_eq("rst_data", data_o, 0);
    #5 rst_ni = 1'b1;

    run_tile(4, 4, 0, 1, 0);   // full tile, no backpressure
    run_tile(2, 3, 0, 1, 0);   // partial tile
    run_tile(0, 4, 0, 1, 0);   // zero rows
    run_tile(4, 4, 1, 0, 0);   // random backpressure
    run_tile(4, 2, 1, 0, 1);   // start while busy, stalled
    run_tile(4, 4, 0, 1, 1);   // start while busy, full rate
    clear_mid_drain();
    run_tile(4, 4, 0, 1, 0);   // fresh tile after clear starts at row 0
    for (int i = 0; i < 12; i++) begin
      int rows = $urandom_range(0, ROWS);
      int cols = $urandom_range(0, COLS);
      run_tile(rows, cols, 1, 0, (rows == ROWS) && (i % 2 == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
